// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the MIPS CPU instruction memory.
// Assembles big-endian words, zero-fills the remaining words, then releases the CPU.
module program_loader #(
    parameter int INSTR_MEM_SIZE = 64,
    parameter int ADDR_WIDTH     = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  error
);
    localparam int IDX_W = ADDR_WIDTH + 1;
    localparam logic [15:0]      MEM_WORDS = 16'(INSTR_MEM_SIZE);
    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(INSTR_MEM_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, WORD, FILL, DONE, ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [23:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  run_q, run_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic [15:0]           len_full;
    logic [IDX_W-1:0]      idx_inc;

    assign in_ready   = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == WORD);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_run    = run_q;
    assign error      = err_q;

    assign xfer     = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        run_d      = run_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LEN_HI;
                    idx_d      = '0;
                    byte_idx_d = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full > MEM_WORDS) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        // Empty program: issue the addr-0 fill now so fill starts right after LEN_LO.
                        we_d    = 1'b1;
                        addr_d  = '0;
                        wdata_d = '0;
                        idx_d   = {{(IDX_W-1){1'b0}}, 1'b1};
                        state_d = (LAST_ADDR == '0) ? DONE : FILL;
                    end else begin
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = idx_q[ADDR_WIDTH-1:0];
                        wdata_d    = {asm_q, in_data};
                        idx_d      = idx_inc;
                        byte_idx_d = '0;
                        if (16'(idx_inc) == len_q) begin
                            state_d = (len_q == MEM_WORDS) ? DONE : FILL;
                        end
                    end else begin
                        asm_d      = {asm_q[15:0], in_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            FILL: begin
                we_d    = 1'b1;
                addr_d  = idx_q[ADDR_WIDTH-1:0];
                wdata_d = '0;
                idx_d   = idx_inc;
                if (idx_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                run_d = 1'b1;
                if (start) begin
                    run_d      = 1'b0;
                    state_d    = LEN_HI;
                    idx_d      = '0;
                    byte_idx_d = '0;
                end
            end
            ERROR: begin
                if (start) begin
                    err_d      = 1'b0;
                    state_d    = LEN_HI;
                    idx_d      = '0;
                    byte_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_idx_q <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            run_q      <= run_d;
            err_q      <= err_d;
        end
    end

endmodule
